// File: rtl/jacobian_mult_pkg.sv
// Shared types and constants for the shared-multiplier server: Q8.27 fixed point,
// lane counts, mode/state enums and the shift-and-saturate helper.
package jacobian_mult_pkg;
  localparam int FIX_W       = 36;
  localparam int FRAC_BITS   = 27;
  localparam int ARRAY_LANES = 9;
  localparam int MAT_LANES   = 36;
  localparam int LANE_IDX_W  = 6;

  typedef logic [FIX_W-1:0] fix_t;
  typedef logic [MAT_LANES-1:0][FIX_W-1:0] lane_vec_t;

  localparam fix_t FIX_ONE = 36'h008000000;
  localparam fix_t FIX_MAX = 36'h7FFFFFFFF;
  localparam fix_t FIX_MIN = 36'h800000000;

  typedef enum logic {MODE_ARRAY = 1'b0, MODE_MATRIX = 1'b1} mode_e;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  typedef struct packed {
    fix_t value;
    logic sat;
  } lane_out_t;

  // Floor shift of the full product; anything that does not fit FIX_W clamps.
  function automatic lane_out_t shift_sat(input logic signed [2*FIX_W-1:0] prod);
    logic signed [2*FIX_W-1:0] sh;
    lane_out_t r;
    sh = prod >>> FRAC_BITS;
    r.sat = !((&sh[2*FIX_W-1:FIX_W-1]) || !(|sh[2*FIX_W-1:FIX_W-1]));
    if (r.sat) r.value = prod[2*FIX_W-1] ? FIX_MIN : FIX_MAX;
    else       r.value = sh[FIX_W-1:0];
    return r;
  endfunction
endpackage

// File: rtl/jacobian_mult_server_if.sv
// Request/response bundle between full_jacobian (master) and the multiplier server (slave).
// Handshake: a request transfers on a clk edge where req_valid & req_ready; rsp_valid is a one-cycle pulse with no backpressure.
interface jacobian_mult_server_if;
  import jacobian_mult_pkg::*;
  logic      req_valid;
  logic      req_ready;
  logic      req_mode;
  lane_vec_t req_dataa;
  lane_vec_t req_datab;
  logic      rsp_valid;
  logic      rsp_mode;
  lane_vec_t rsp_result;
  logic      rsp_sat;

  modport master (output req_valid, req_mode, req_dataa, req_datab,
                  input  req_ready, rsp_valid, rsp_mode, rsp_result, rsp_sat);
  modport slave  (input  req_valid, req_mode, req_dataa, req_datab,
                  output req_ready, rsp_valid, rsp_mode, rsp_result, rsp_sat);
endinterface

// File: rtl/fix_mult_lane.sv
// One pipelined signed fixed-point multiplier: MULT_LAT stages carrying the full
// product, a valid bit and the destination lane tag; shift/saturate at the output.
module fix_mult_lane
  import jacobian_mult_pkg::*;
#(
  parameter int MULT_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [LANE_IDX_W-1:0] in_tag,
  input  fix_t                  in_a,
  input  fix_t                  in_b,
  output logic                  out_valid,
  output logic [LANE_IDX_W-1:0] out_tag,
  output fix_t                  out_result,
  output logic                  out_sat
);
  typedef logic signed [2*FIX_W-1:0] prod_t;

  logic [MULT_LAT-1:0]                 vld_q, vld_d;
  logic [MULT_LAT-1:0][LANE_IDX_W-1:0] tag_q, tag_d;
  logic [MULT_LAT-1:0][2*FIX_W-1:0]    prod_q, prod_d;
  prod_t     a_ext, b_ext;
  lane_out_t res;

  always_comb begin
    a_ext     = prod_t'($signed(in_a));
    b_ext     = prod_t'($signed(in_b));
    vld_d[0]  = in_valid;
    tag_d[0]  = in_tag;
    prod_d[0] = a_ext * b_ext;
    for (int s = 1; s < MULT_LAT; s++) begin
      vld_d[s]  = vld_q[s-1];
      tag_d[s]  = tag_q[s-1];
      prod_d[s] = prod_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      tag_q  <= '0;
      prod_q <= '0;
    end else begin
      vld_q  <= vld_d;
      tag_q  <= tag_d;
      prod_q <= prod_d;
    end
  end

  always_comb res = shift_sat(prod_q[MULT_LAT-1]);

  assign out_valid  = vld_q[MULT_LAT-1];
  assign out_tag    = tag_q[MULT_LAT-1];
  assign out_result = res.value;
  assign out_sat    = res.sat;
endmodule

// File: rtl/jacobian_mult_server.sv
// Shared-multiplier responder: latches one 9- or 36-lane request, streams it over
// NUM_MULT pipelined lanes in beats, and pulses rsp_valid once every lane has retired.
module jacobian_mult_server
  import jacobian_mult_pkg::*;
#(
  parameter int NUM_MULT = 9,
  parameter int MULT_LAT = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  jacobian_mult_server_if.slave        bus,
  output logic                         busy,
  output state_e                       dbg_state
);
  localparam int MAT_BEATS = MAT_LANES / NUM_MULT;
  localparam int ARR_BEATS = (ARRAY_LANES + NUM_MULT - 1) / NUM_MULT;
  localparam logic [LANE_IDX_W-1:0] MAT_LAST  = LANE_IDX_W'(MAT_BEATS - 1);
  localparam logic [LANE_IDX_W-1:0] ARR_LAST  = LANE_IDX_W'(ARR_BEATS - 1);
  localparam logic [7:0]            DRAIN_LAST = 8'(MULT_LAT - 1);

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [LANE_IDX_W-1:0] beat_q, beat_d;
  logic [7:0]            drain_q, drain_d;
  lane_vec_t             dataa_q, dataa_d, datab_q, datab_d;
  lane_vec_t             result_q, result_d;
  logic                  sat_q, sat_d, rsp_valid_q, rsp_valid_d;
  logic                  ready_q, ready_d, busy_q, busy_d;

  logic [NUM_MULT-1:0]                 in_valid, out_valid, out_sat;
  logic [NUM_MULT-1:0][LANE_IDX_W-1:0] in_tag, out_tag;
  logic [NUM_MULT-1:0][FIX_W-1:0]      in_a, in_b, out_res;
  int                                  active_lanes;

  // Beat k drives lanes k*NUM_MULT + m; lanes past the mode's lane count stay idle.
  always_comb begin
    active_lanes = (mode_q == MODE_MATRIX) ? MAT_LANES : ARRAY_LANES;
    for (int m = 0; m < NUM_MULT; m++) begin
      in_tag[m]   = LANE_IDX_W'(int'(beat_q) * NUM_MULT + m);
      in_valid[m] = (state_q == ISSUE) && ((int'(beat_q) * NUM_MULT + m) < active_lanes);
      in_a[m]     = dataa_q[in_tag[m]];
      in_b[m]     = datab_q[in_tag[m]];
    end
  end

  for (genvar g = 0; g < NUM_MULT; g++) begin : g_lane
    fix_mult_lane #(.MULT_LAT(MULT_LAT)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_tag    (in_tag[g]),
      .in_a      (in_a[g]),
      .in_b      (in_b[g]),
      .out_valid (out_valid[g]),
      .out_tag   (out_tag[g]),
      .out_result(out_res[g]),
      .out_sat   (out_sat[g])
    );
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    beat_d      = beat_q;
    drain_d     = drain_q;
    dataa_d     = dataa_q;
    datab_d     = datab_q;
    result_d    = result_q;
    sat_d       = sat_q;
    rsp_valid_d = 1'b0;
    unique case (state_q)
      IDLE: if (bus.req_valid) begin
        state_d = ISSUE;
        mode_d  = mode_e'(bus.req_mode);
        dataa_d = bus.req_dataa;
        datab_d = bus.req_datab;
        beat_d  = '0;
        sat_d   = 1'b0;
        for (int l = ARRAY_LANES; l < MAT_LANES; l++)
          if (bus.req_mode == MODE_ARRAY) result_d[l] = '0;
      end
      ISSUE: begin
        if (beat_q == ((mode_q == MODE_MATRIX) ? MAT_LAST : ARR_LAST)) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // The pipeline is empty whenever a request is accepted, so retirement never collides with it.
    for (int m = 0; m < NUM_MULT; m++) begin
      if (out_valid[m]) begin
        result_d[out_tag[m]] = out_res[m];
        sat_d                = sat_d | out_sat[m];
      end
    end
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= MODE_ARRAY;
      beat_q      <= '0;
      drain_q     <= '0;
      dataa_q     <= '0;
      datab_q     <= '0;
      result_q    <= '0;
      sat_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      beat_q      <= beat_d;
      drain_q     <= drain_d;
      dataa_q     <= dataa_d;
      datab_q     <= datab_d;
      result_q    <= result_d;
      sat_q       <= sat_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_mode   = mode_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_sat    = sat_q;
  assign busy           = busy_q;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_jacobian_mult_server.sv
// Directed bench for jacobian_mult_server: reset, array/matrix products, saturation,
// back-to-back requests and reset during an in-flight request.
module tb_jacobian_mult_server;
  import jacobian_mult_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   busy;
  state_e dbg_state;
  int     tests_run = 0;
  int     tests_failed = 0;

  jacobian_mult_server_if bus();

  jacobian_mult_server #(.NUM_MULT(9), .MULT_LAT(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic scramble_inputs();
    for (int l = 0; l < MAT_LANES; l++) begin
      bus.req_dataa[l] = FIX_W'({$urandom(), $urandom()});
      bus.req_datab[l] = FIX_W'({$urandom(), $urandom()});
    end
    bus.req_mode = 1'(($urandom_range(0, 1)));
  endtask

  // Drives one request; lat = negedges after the accept edge until rsp_valid (-1 on timeout).
  task automatic run_request(input logic mode, input lane_vec_t a, input lane_vec_t b,
                             input string name, output int lat, output int ready_hi);
    lat = -1;
    ready_hi = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_mode  = mode;
    bus.req_dataa = a;
    bus.req_datab = b;
    tests_run++;
    if (bus.req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s ready_before_accept: got %b want 1", name, bus.req_ready);
    end
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bus.req_valid = 1'b0;
        scramble_inputs();
      end
      if (bus.req_ready !== 1'b0 || busy !== 1'b1) ready_hi++;
      if (bus.rsp_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    scramble_inputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
    tests_run++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_sat !== 1'b0 || bus.rsp_mode !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_rsp: valid/sat/mode got %b%b%b want 000", bus.rsp_valid, bus.rsp_sat, bus.rsp_mode);
    end
    tests_run++;
    if (busy !== 1'b0 || dbg_state !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_busy: busy %b state %0d want 0 / IDLE", busy, dbg_state);
    end
    tests_run++;
    if (bus.rsp_result !== '0) begin tests_failed++; $display("FAIL reset_result: got nonzero want all zero"); end
  endtask

  task automatic test_array();
    lane_vec_t a, b, e;
    int lat, rhi, bad;
    a = '0; b = '0; e = '0;
    a[0] = 36'h00C000000; b[0] = 36'h010000000; e[0] = 36'h018000000;
    a[1] = 36'hFF8000000; b[1] = 36'h004000000; e[1] = 36'hFFC000000;
    for (int l = ARRAY_LANES; l < MAT_LANES; l++) begin a[l] = FIX_ONE; b[l] = FIX_ONE; end
    run_request(1'b0, a, b, "array", lat, rhi);
    tests_run++;
    if (lat != 4) begin tests_failed++; $display("FAIL array_latency: got %0d want 4", lat); end
    tests_run++;
    if (rhi != 0) begin tests_failed++; $display("FAIL array_ready_low: ready/busy wrong in %0d cycles want 0", rhi); end
    bad = -1;
    for (int l = 0; l < MAT_LANES; l++) if (bad < 0 && bus.rsp_result[l] !== e[l]) bad = l;
    tests_run++;
    if (bad >= 0) begin tests_failed++; $display("FAIL array_result lane %0d: got %h want %h", bad, bus.rsp_result[bad], e[bad]); end
    tests_run++;
    if (bus.rsp_sat !== 1'b0 || bus.rsp_mode !== 1'b0) begin
      tests_failed++; $display("FAIL array_sat_mode: got sat %b mode %b want 0 0", bus.rsp_sat, bus.rsp_mode);
    end
    @(negedge clk);
    tests_run++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_result !== e) begin
      tests_failed++;
      $display("FAIL array_after: valid %b ready %b held %b want 0 1 1", bus.rsp_valid, bus.req_ready, bus.rsp_result === e);
    end
  endtask

  task automatic test_matrix();
    lane_vec_t a, b, e;
    int lat, rhi, bad;
    for (int i = 0; i < MAT_LANES; i++) begin
      a[i] = FIX_W'(i + 1) << FRAC_BITS;
      b[i] = 36'h008000000;
      e[i] = FIX_W'(i + 1) << FRAC_BITS;
    end
    run_request(1'b1, a, b, "matrix", lat, rhi);
    tests_run++;
    if (lat != 7) begin tests_failed++; $display("FAIL matrix_latency: got %0d want 7", lat); end
    tests_run++;
    if (rhi != 0) begin tests_failed++; $display("FAIL matrix_ready_low: ready/busy wrong in %0d cycles want 0", rhi); end
    bad = -1;
    for (int l = 0; l < MAT_LANES; l++) if (bad < 0 && bus.rsp_result[l] !== e[l]) bad = l;
    tests_run++;
    if (bad >= 0) begin tests_failed++; $display("FAIL matrix_result lane %0d: got %h want %h", bad, bus.rsp_result[bad], e[bad]); end
    tests_run++;
    if (bus.rsp_mode !== 1'b1 || bus.rsp_sat !== 1'b0) begin
      tests_failed++; $display("FAIL matrix_mode_sat: got mode %b sat %b want 1 0", bus.rsp_mode, bus.rsp_sat);
    end
    @(negedge clk);
    tests_run++;
    if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL matrix_ready_return: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_saturation();
    lane_vec_t a, b, e;
    int lat, rhi, bad;
    a = '0; b = '0; e = '0;
    a[0] = 36'h080000000; b[0] = 36'h100000000; e[0] = 36'h7FFFFFFFF;
    a[1] = 36'hF80000000; b[1] = 36'h100000000; e[1] = 36'h800000000;
    a[2] = 36'h000000001; b[2] = 36'h000000001; e[2] = 36'h000000000;
    a[3] = 36'hFFFFFFFFF; b[3] = 36'h000000001; e[3] = 36'hFFFFFFFFF;
    run_request(1'b0, a, b, "sat", lat, rhi);
    tests_run++;
    if (lat != 4) begin tests_failed++; $display("FAIL sat_latency: got %0d want 4", lat); end
    bad = -1;
    for (int l = 0; l < MAT_LANES; l++) if (bad < 0 && bus.rsp_result[l] !== e[l]) bad = l;
    tests_run++;
    if (bad >= 0) begin tests_failed++; $display("FAIL sat_result lane %0d: got %h want %h", bad, bus.rsp_result[bad], e[bad]); end
    tests_run++;
    if (bus.rsp_sat !== 1'b1) begin tests_failed++; $display("FAIL sat_flag: got %b want 1", bus.rsp_sat); end
  endtask

  task automatic test_back_to_back();
    lane_vec_t a1, b1, e1, a2, b2, e2;
    int rsp1_n, acc_n, rsp2_n, bad;
    logic held_ok;
    rsp1_n = -1; acc_n = -1; rsp2_n = -1; held_ok = 1'b0;
    a1 = '0; b1 = '0; e1 = '0;
    a1[4] = 36'h00C000000; b1[4] = 36'h010000000; e1[4] = 36'h018000000;
    a1[8] = 36'hFF8000000; b1[8] = 36'h004000000; e1[8] = 36'hFFC000000;
    for (int i = 0; i < MAT_LANES; i++) begin
      a2[i] = FIX_W'(i + 1) << FRAC_BITS;
      b2[i] = 36'hFF8000000;
      e2[i] = 36'h0 - (FIX_W'(i + 1) << FRAC_BITS);
    end
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_mode = 1'b0; bus.req_dataa = a1; bus.req_datab = b1;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin bus.req_mode = 1'b1; bus.req_dataa = a2; bus.req_datab = b2; end
      if (acc_n >= 0 && n == acc_n + 1) begin bus.req_valid = 1'b0; scramble_inputs(); end
      if (acc_n < 0 && bus.rsp_valid === 1'b1) begin
        rsp1_n = n;
        tests_run++;
        if (bus.rsp_result !== e1 || bus.rsp_sat !== 1'b0 || bus.rsp_mode !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b_first_rsp: lane4 %h lane8 %h sat %b want %h %h 0", bus.rsp_result[4], bus.rsp_result[8], bus.rsp_sat, e1[4], e1[8]);
        end
      end
      if (acc_n < 0 && bus.req_ready === 1'b1) begin
        acc_n = n;
        held_ok = (bus.rsp_result === e1);
      end else if (acc_n >= 0 && bus.rsp_valid === 1'b1) begin
        rsp2_n = n;
        break;
      end
    end
    tests_run++;
    if (rsp1_n != 4 || acc_n != 5) begin
      tests_failed++; $display("FAIL b2b_timing: rsp1 %0d accept %0d want 4 5", rsp1_n, acc_n);
    end
    tests_run++;
    if (held_ok !== 1'b1) begin tests_failed++; $display("FAIL b2b_held: got %b want 1", held_ok); end
    tests_run++;
    if (rsp2_n != 12) begin tests_failed++; $display("FAIL b2b_second_latency: got %0d want 12", rsp2_n); end
    bad = -1;
    for (int l = 0; l < MAT_LANES; l++) if (bad < 0 && bus.rsp_result[l] !== e2[l]) bad = l;
    tests_run++;
    if (bad >= 0) begin tests_failed++; $display("FAIL b2b_second_result lane %0d: got %h want %h", bad, bus.rsp_result[bad], e2[bad]); end
  endtask

  task automatic test_reset_mid();
    lane_vec_t a, b, e;
    int spurious, lat, rhi;
    spurious = 0;
    for (int i = 0; i < MAT_LANES; i++) begin a[i] = FIX_ONE; b[i] = FIX_ONE; end
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_mode = 1'b1; bus.req_dataa = a; bus.req_datab = b;
    @(posedge clk);
    @(negedge clk); bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.req_ready !== 1'b1 || busy !== 1'b0 || dbg_state !== IDLE) begin
      tests_failed++; $display("FAIL midreset_async: ready %b busy %b state %0d want 1 0 IDLE", bus.req_ready, busy, dbg_state);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) spurious++;
    end
    tests_run++;
    if (spurious != 0) begin tests_failed++; $display("FAIL midreset_no_rsp: got %0d pulses want 0", spurious); end
    a = '0; b = '0; e = '0;
    a[2] = 36'h010000000; b[2] = 36'h010000000; e[2] = 36'h020000000;
    run_request(1'b0, a, b, "midreset_next", lat, rhi);
    tests_run++;
    if (lat != 4 || bus.rsp_result !== e) begin
      tests_failed++; $display("FAIL midreset_next: lat %0d lane2 %h want 4 %h", lat, bus.rsp_result[2], e[2]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_mode  = 1'b0;
    bus.req_dataa = '0;
    bus.req_datab = '0;
    test_reset();
    test_array();
    test_matrix();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
